// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared types, constants and helpers for the ECC scrubber
package ecc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_CHECK,
        S_WR_REQ
    } scrub_state_e;

    localparam int CNT_W = 16;

    function automatic int ham_syn_w(input int n, input int k);
        return n - k;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ham_dec_core.sv
// rtl/ham_dec_core.sv - combinational single-error-correcting Hamming decoder
module ham_dec_core
    import ecc_pkg::*;
#(
    parameter int N = 7,
    parameter int K = 4
) (
    input  logic [N-1:0]                cw,
    output logic [ham_syn_w(N, K)-1:0]  syn,
    output logic [N-1:0]                corr_cw,
    output logic                        err,
    output logic                        uncorr
);
    localparam int SW = ham_syn_w(N, K);

    always_comb begin
        syn = '0;
        for (int p = 1; p <= N; p++) begin
            for (int j = 0; j < SW; j++) begin
                if (((p >> j) & 1) != 0) begin
                    syn[j] = syn[j] ^ cw[p-1];
                end
            end
        end
        // Syndromes beyond N only exist for shortened codes and point at no real bit.
        uncorr  = int'(syn) > N;
        err     = (syn != '0) && !uncorr;
        corr_cw = cw;
        for (int i = 0; i < N; i++) begin
            if (err && (int'(syn) == i + 1)) begin
                corr_cw[i] = ~cw[i];
            end
        end
    end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// rtl/ecc_scrub_ctrl.sv - background RAM scrubber: read, decode, write back corrected words
module ecc_scrub_ctrl
    import ecc_pkg::*;
#(
    parameter int N           = 7,
    parameter int K           = 4,
    parameter int AW          = 8,
    parameter int DEPTH       = 256,
    parameter int IDLE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             mem_req,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [N-1:0]     mem_wdata,
    input  logic             mem_gnt,
    input  logic [N-1:0]     mem_rdata,
    output logic             busy,
    output logic             pass_done,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] ucorr_cnt,
    output logic [AW-1:0]    last_err_addr
);
    localparam int SW = ham_syn_w(N, K);
    localparam int WW = $clog2(IDLE_CYCLES + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    scrub_state_e     state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    last_err_q, last_err_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [N-1:0]     word_q, word_d;
    logic [N-1:0]     wdata_q, wdata_d;
    logic [CNT_W-1:0] corr_q, corr_d;
    logic [CNT_W-1:0] ucorr_q, ucorr_d;
    logic             pass_done_q, pass_done_d;
    logic             advance;

    logic [SW-1:0]    syn;
    logic [N-1:0]     corr_cw;
    logic             err;
    logic             uncorr;

    ham_dec_core #(.N(N), .K(K)) u_dec (
        .cw      (word_q),
        .syn     (syn),
        .corr_cw (corr_cw),
        .err     (err),
        .uncorr  (uncorr)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_err_d  = last_err_q;
        wait_d      = wait_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        corr_d      = corr_q;
        ucorr_d     = ucorr_q;
        pass_done_d = 1'b0;
        advance     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_RD_REQ;
                    addr_d  = '0;
                end
            end
            S_WAIT: begin
                if (!en) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else if (wait_q <= WW'(1)) begin
                    state_d = S_RD_REQ;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            S_RD_REQ: begin
                if (mem_gnt) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                word_d  = mem_rdata;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (syn == '0) begin
                    advance = 1'b1;
                end else if (err) begin
                    wdata_d    = corr_cw;
                    corr_d     = sat_inc(corr_q);
                    last_err_d = addr_q;
                    state_d    = S_WR_REQ;
                end else begin
                    ucorr_d    = sat_inc(ucorr_q);
                    last_err_d = addr_q;
                    advance    = 1'b1;
                end
            end
            S_WR_REQ: begin
                if (mem_gnt) advance = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Enable is only honoured between words so a started access always finishes.
        if (advance) begin
            if (addr_q == LAST_ADDR) begin
                pass_done_d = 1'b1;
                addr_d      = '0;
                wait_d      = WW'(IDLE_CYCLES);
                state_d     = en ? S_WAIT : S_IDLE;
            end else if (en) begin
                addr_d  = addr_q + AW'(1);
                state_d = S_RD_REQ;
            end else begin
                addr_d  = '0;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_err_q  <= '0;
            wait_q      <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            corr_q      <= '0;
            ucorr_q     <= '0;
            pass_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_err_q  <= last_err_d;
            wait_q      <= wait_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            corr_q      <= corr_d;
            ucorr_q     <= ucorr_d;
            pass_done_q <= pass_done_d;
        end
    end

    assign mem_req       = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign mem_we        = (state_q == S_WR_REQ);
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_WAIT);
    assign pass_done     = pass_done_q;
    assign corr_cnt      = corr_q;
    assign ucorr_cnt     = ucorr_q;
    assign last_err_addr = last_err_q;

endmodule
